// File: rtl/spi_burst_pkg.sv
// Shared definitions for the SPI burst controller: register map, transfer
// FSM states and CTRL/STATUS bit positions.
package spi_burst_pkg;

   typedef enum logic [1:0] {
      ADDR_CTRL   = 2'd0,
      ADDR_TXDATA = 2'd1,
      ADDR_RXDATA = 2'd2,
      ADDR_STATUS = 2'd3
   } reg_addr_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_STORE = 2'd3
   } xfer_state_e;

   localparam int CTRL_DIV_LSB   = 0;
   localparam int CTRL_DIV_W     = 9;
   localparam int CTRL_CS_BIT    = 9;
   localparam int CTRL_FLUSH_BIT = 10;

   localparam int STATUS_TXCNT_LSB = 0;
   localparam int STATUS_RXCNT_LSB = 5;
   localparam int STATUS_CNT_W     = 5;
   localparam int STATUS_BUSY_BIT  = 10;
   localparam int STATUS_OVF_BIT   = 11;

   localparam logic [8:0] DIVIDER_RST = 9'h1FF;
   localparam logic [7:0] TX_DATA_RST = 8'hFF;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte-wide show-ahead FIFO with occupancy count and synchronous flush.
// Push is ignored when full, pop is ignored when empty.
module spi_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [7:0]               push_data_i,
   input  logic                     pop_i,
   output logic [7:0]               head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Simultaneous push and pop leave the occupancy unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Register-mapped SPI burst controller: TX/RX byte FIFOs feeding an external
// byte engine one byte at a time, with a CTRL/TXDATA/RXDATA/STATUS bus.
module spi_burst_ctrl
   import spi_burst_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_access,
   input  logic        reg_wr_en,
   input  logic [1:0]  reg_addr,
   input  logic [15:0] reg_wdata,
   output logic [15:0] reg_rdata,
   output logic        reg_ack,
   output logic [8:0]  divider,
   output logic        xfer_start,
   output logic [7:0]  tx_data,
   input  logic        xfer_complete,
   input  logic [7:0]  rx_data,
   output logic        cs_n
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   reg_addr_e     addr;
   logic          access_fire;
   logic          wr_fire;
   logic          rd_fire;
   logic          flush;
   logic          bus_tx_push;
   logic          bus_rx_pop;
   logic          status_ovf_clr;
   logic          start_go;
   logic          fsm_rx_push;
   logic          busy;

   logic [7:0]    tx_head;
   logic [7:0]    rx_head;
   logic [CW-1:0] tx_count;
   logic [CW-1:0] rx_count;
   logic          tx_full;
   logic          tx_empty;
   logic          rx_full;
   logic          rx_empty;

   logic          reg_ack_q;
   logic [15:0]   reg_rdata_q;
   logic [15:0]   reg_rdata_d;
   logic [8:0]    divider_q;
   logic          cs_active_q;
   logic          overflow_q;

   xfer_state_e   state_q;
   logic          xfer_start_q;
   logic [7:0]    tx_data_q;
   logic [7:0]    rx_byte_q;
   logic          discard_q;

   logic          unused_ok;
   assign unused_ok = ^{reg_wdata[15:12], rx_full};

   assign addr        = reg_addr_e'(reg_addr);
   assign access_fire = reg_access & ~reg_ack_q;
   assign wr_fire     = access_fire & reg_wr_en;
   assign rd_fire     = access_fire & ~reg_wr_en;

   assign flush          = wr_fire && (addr == ADDR_CTRL) && reg_wdata[CTRL_FLUSH_BIT];
   assign bus_tx_push    = wr_fire && (addr == ADDR_TXDATA);
   assign bus_rx_pop     = rd_fire && (addr == ADDR_RXDATA);
   assign status_ovf_clr = wr_fire && (addr == ADDR_STATUS) && reg_wdata[STATUS_OVF_BIT];

   // Only IDLE may launch, and nothing is in flight there, so RX room is
   // simply the current RX occupancy. A same-cycle flush suppresses the launch.
   assign start_go    = (state_q == ST_IDLE) && !tx_empty &&
                        (rx_count < CW'(FIFO_DEPTH)) && !flush;
   assign fsm_rx_push = (state_q == ST_STORE) && !discard_q;
   assign busy        = (state_q != ST_IDLE) || !tx_empty;

   spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .push_i      (bus_tx_push),
      .push_data_i (reg_wdata[7:0]),
      .pop_i       (start_go),
      .head_o      (tx_head),
      .count_o     (tx_count),
      .full_o      (tx_full),
      .empty_o     (tx_empty)
   );

   spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .push_i      (fsm_rx_push),
      .push_data_i (rx_byte_q),
      .pop_i       (bus_rx_pop),
      .head_o      (rx_head),
      .count_o     (rx_count),
      .full_o      (rx_full),
      .empty_o     (rx_empty)
   );

   always_comb begin
      reg_rdata_d = '0;
      if (rd_fire) begin
         case (addr)
            ADDR_CTRL: begin
               reg_rdata_d[CTRL_DIV_LSB +: CTRL_DIV_W] = divider_q;
               reg_rdata_d[CTRL_CS_BIT]                = cs_active_q;
            end
            ADDR_TXDATA: reg_rdata_d = '0;
            ADDR_RXDATA: begin
               if (!rx_empty) reg_rdata_d[7:0] = rx_head;
            end
            ADDR_STATUS: begin
               reg_rdata_d[STATUS_TXCNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(tx_count);
               reg_rdata_d[STATUS_RXCNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(rx_count);
               reg_rdata_d[STATUS_BUSY_BIT]                  = busy;
               reg_rdata_d[STATUS_OVF_BIT]                   = overflow_q;
            end
            default: reg_rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_ack_q   <= 1'b0;
         reg_rdata_q <= '0;
         divider_q   <= DIVIDER_RST;
         cs_active_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         reg_ack_q   <= access_fire;
         reg_rdata_q <= reg_rdata_d;
         if (wr_fire && (addr == ADDR_CTRL)) begin
            divider_q   <= reg_wdata[CTRL_DIV_LSB +: CTRL_DIV_W];
            cs_active_q <= reg_wdata[CTRL_CS_BIT];
         end
         if (flush || status_ovf_clr) begin
            overflow_q <= 1'b0;
         end else if (bus_tx_push && tx_full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // The TX pop and tx_data load happen on the edge into START so that
   // xfer_start and the byte are presented together for the START cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         xfer_start_q <= 1'b0;
         tx_data_q    <= TX_DATA_RST;
         rx_byte_q    <= '0;
         discard_q    <= 1'b0;
      end else begin
         xfer_start_q <= 1'b0;
         if (flush && (state_q != ST_IDLE)) discard_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (start_go) begin
                  tx_data_q    <= tx_head;
                  xfer_start_q <= 1'b1;
                  state_q      <= ST_START;
               end
            end
            ST_START: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (xfer_complete) begin
                  rx_byte_q <= rx_data;
                  state_q   <= ST_STORE;
               end
            end
            ST_STORE: begin
               discard_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign reg_ack    = reg_ack_q;
   assign reg_rdata  = reg_rdata_q;
   assign divider    = divider_q;
   assign cs_n       = ~cs_active_q;
   assign xfer_start = xfer_start_q;
   assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl: bus reads queue their expected data,
// a monitor compares on every reg_ack; a stub byte engine answers transfers.
module tb_spi_burst_ctrl;
   import spi_burst_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        reg_access;
   logic        reg_wr_en;
   logic [1:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata;
   logic        reg_ack;
   logic [8:0]  divider;
   logic        xfer_start;
   logic [7:0]  tx_data;
   logic        xfer_complete;
   logic [7:0]  rx_data;
   logic        cs_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_burst_ctrl #(.FIFO_DEPTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .reg_access    (reg_access),
      .reg_wr_en     (reg_wr_en),
      .reg_addr      (reg_addr),
      .reg_wdata     (reg_wdata),
      .reg_rdata     (reg_rdata),
      .reg_ack       (reg_ack),
      .divider       (divider),
      .xfer_start    (xfer_start),
      .tx_data       (tx_data),
      .xfer_complete (xfer_complete),
      .rx_data       (rx_data),
      .cs_n          (cs_n)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      string       name;
      logic [15:0] exp;
   } exp_t;
   exp_t sb_q[$];

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reg_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got rdata %h expected no ack", reg_rdata);
            end else begin
               e = sb_q.pop_front();
               chk(e.name, reg_rdata, e.exp);
            end
         end
      end
   end

   task automatic bus_xact(input logic wr, input logic [1:0] a, input logic [15:0] d,
                           input string name, input logic [15:0] exp);
      exp_t e;
      @(posedge clk); #1;
      reg_access = 1'b1;
      reg_wr_en  = wr;
      reg_addr   = a;
      reg_wdata  = d;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
      @(posedge clk); #1;
      reg_access = 1'b0;
      reg_wr_en  = 1'b0;
      reg_wdata  = '0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      bus_xact(1'b1, a, d, "write_ack_rdata_zero", 16'h0000);
   endtask

   task automatic rd(input logic [1:0] a, input string name, input logic [15:0] exp);
      bus_xact(1'b0, a, 16'h0000, name, exp);
   endtask

   // ---------------- stub byte engine ----------------
   int         n_starts   = 0;
   int         n_done     = 0;
   int         eng_lat    = 20;
   bit         eng_stall  = 1'b0;
   bit         eng_manual = 1'b0;
   logic [7:0] seen_tx[$];

   initial begin : engine
      logic [7:0] held;
      bit         stable;
      bit         overlap;
      int         cnt;
      xfer_complete = 1'b0;
      rx_data       = 8'h00;
      forever begin
         @(negedge clk);
         if (xfer_start === 1'b1) begin
            n_starts++;
            seen_tx.push_back(tx_data);
            $display("xfer_start #%0d tx_data=%h", n_starts, tx_data);
            if (!eng_manual) begin
               held    = tx_data;
               stable  = 1'b1;
               overlap = 1'b0;
               cnt     = 0;
               while (eng_stall || cnt < eng_lat) begin
                  @(negedge clk);
                  cnt++;
                  if (tx_data !== held) stable = 1'b0;
                  if (xfer_start === 1'b1) overlap = 1'b1;
               end
               @(posedge clk); #1;
               xfer_complete = 1'b1;
               rx_data       = held ^ 8'h99;
               @(posedge clk); #1;
               xfer_complete = 1'b0;
               n_done++;
               chk("tx_data_held", 16'(stable), 16'd1);
               chk("single_outstanding", 16'(overlap), 16'd0);
            end
         end
      end
   end

   task automatic wait_done(input int n, input int budget, input string name);
      int k = 0;
      while (n_done < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, 16'(n_done >= n ? 1 : 0), 16'd1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   logic [7:0] c_exp [9];
   int         base_s;
   int         base_d;
   bit         ninth_seen;

   initial begin : stim
      c_exp = '{8'hB8, 8'hBB, 8'hBA, 8'hBD, 8'hBC, 8'hBF, 8'hBE, 8'hB1, 8'hB0};
      reset      = 1'b1;
      reg_access = 1'b0;
      reg_wr_en  = 1'b0;
      reg_addr   = 2'd0;
      reg_wdata  = '0;
      #12;
      chk("rst_rdata", reg_rdata, 16'h0000);
      chk("rst_ack", 16'(reg_ack), 16'd0);
      chk("rst_divider", 16'(divider), 16'h01FF);
      chk("rst_cs_n", 16'(cs_n), 16'd1);
      chk("rst_xfer_start", 16'(xfer_start), 16'd0);
      chk("rst_tx_data", 16'(tx_data), 16'h00FF);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single transfer, divider/cs, readback
      wr(ADDR_CTRL, 16'h0203);
      chk("a_divider", 16'(divider), 16'h0003);
      chk("a_cs_n", 16'(cs_n), 16'd0);
      rd(ADDR_STATUS, "a_status_empty", 16'h0000);
      wr(ADDR_TXDATA, 16'h00A5);
      wait_done(1, 200, "a_done");
      repeat (4) @(posedge clk);
      chk("a_starts", 16'(n_starts), 16'd1);
      chk("a_tx_byte", 16'(seen_tx[0]), 16'h00A5);
      rd(ADDR_STATUS, "a_status_rx1", 16'h0020);
      rd(ADDR_RXDATA, "a_rxdata", 16'h003C);
      rd(ADDR_RXDATA, "a_rxdata_empty", 16'h0000);
      rd(ADDR_CTRL, "a_ctrl", 16'h0203);
      rd(ADDR_TXDATA, "a_txdata_read", 16'h0000);
      chk("a_cs_n_held", 16'(cs_n), 16'd0);

      // Overflow with a stalled engine, then flush during WAIT
      eng_stall = 1'b1;
      base_s = n_starts;
      base_d = n_done;
      wr(ADDR_TXDATA, 16'h0010);
      for (int i = 1; i <= 9; i++) wr(ADDR_TXDATA, 16'(8'h10 + i));
      rd(ADDR_STATUS, "b_status_ovf", 16'h0C08);
      wr(ADDR_STATUS, 16'h0800);
      rd(ADDR_STATUS, "b_status_ovf_clr", 16'h0408);
      wr(ADDR_CTRL, 16'h0603);
      rd(ADDR_STATUS, "b_status_flushed", 16'h0400);
      eng_stall = 1'b0;
      wait_done(base_d + 1, 100, "b_done");
      repeat (10) @(posedge clk);
      rd(ADDR_STATUS, "b_status_idle", 16'h0000);
      rd(ADDR_CTRL, "b_ctrl_flush_reads0", 16'h0203);
      chk("b_starts", 16'(n_starts - base_s), 16'd1);

      // RX back-pressure: 10 pushes, only 8 transfers until RX is read
      eng_lat = 3;
      base_s = n_starts;
      base_d = n_done;
      for (int i = 0; i < 10; i++) wr(ADDR_TXDATA, 16'(8'h20 + i));
      wait_done(base_d + 8, 400, "c_done8");
      repeat (30) @(posedge clk);
      chk("c_starts8", 16'(n_starts - base_s), 16'd8);
      rd(ADDR_STATUS, "c_status_full", 16'h0502);
      rd(ADDR_RXDATA, "c_rx0", 16'h00B9);
      wait_done(base_d + 9, 100, "c_done9");
      chk("c_ninth_byte", 16'(seen_tx[base_s + 8]), 16'h0028);
      for (int i = 0; i < 8; i++) rd(ADDR_RXDATA, $sformatf("c_rx%0d", i + 1), 16'(c_exp[i]));
      wait_done(base_d + 10, 100, "c_done10");
      rd(ADDR_RXDATA, "c_rx9", 16'(c_exp[8]));
      rd(ADDR_STATUS, "c_status_empty", 16'h0000);

      // RXDATA pop in the same cycle as STORE with RX count 3
      base_d = n_done;
      for (int i = 0; i < 3; i++) wr(ADDR_TXDATA, 16'(8'h30 + i));
      wait_done(base_d + 3, 200, "d_done3");
      repeat (5) @(posedge clk);
      eng_manual = 1'b1;
      base_s = n_starts;
      wr(ADDR_TXDATA, 16'h0033);
      repeat (6) @(posedge clk);
      chk("d_started", 16'(n_starts - base_s), 16'd1);
      #1;
      xfer_complete = 1'b1;
      rx_data       = 8'hAA;
      @(posedge clk); #1;
      xfer_complete = 1'b0;
      begin
         exp_t e;
         reg_access = 1'b1;
         reg_wr_en  = 1'b0;
         reg_addr   = ADDR_RXDATA;
         e.name = "d_rx_during_store";
         e.exp  = 16'h00A9;
         sb_q.push_back(e);
         @(posedge clk); #1;
         reg_access = 1'b0;
      end
      rd(ADDR_STATUS, "d_status_rx3", 16'h0060);
      rd(ADDR_RXDATA, "d_rx1", 16'h00A8);
      rd(ADDR_RXDATA, "d_rx2", 16'h00AB);
      rd(ADDR_RXDATA, "d_rx3", 16'h00AA);
      rd(ADDR_STATUS, "d_status_empty", 16'h0000);

      // Reset in WAIT, then a stray completion
      base_s = n_starts;
      wr(ADDR_TXDATA, 16'h0040);
      repeat (6) @(posedge clk);
      chk("e_tx_data_pre", 16'(tx_data), 16'h0040);
      #3;
      reset = 1'b1;
      #1;
      chk("e_rst_tx_data", 16'(tx_data), 16'h00FF);
      chk("e_rst_divider", 16'(divider), 16'h01FF);
      chk("e_rst_cs_n", 16'(cs_n), 16'd1);
      chk("e_rst_xfer_start", 16'(xfer_start), 16'd0);
      chk("e_rst_ack", 16'(reg_ack), 16'd0);
      chk("e_rst_rdata", reg_rdata, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      xfer_complete = 1'b1;
      rx_data       = 8'h55;
      @(posedge clk); #1;
      xfer_complete = 1'b0;
      repeat (5) @(posedge clk);
      rd(ADDR_STATUS, "e_status_no_push", 16'h0000);
      rd(ADDR_RXDATA, "e_rxdata_empty", 16'h0000);
      rd(ADDR_CTRL, "e_ctrl_reset", 16'h01FF);
      chk("e_starts", 16'(n_starts - base_s), 16'd1);

      // Wrap-up
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
      chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
      ninth_seen = 1'b0;
      foreach (seen_tx[i]) if (seen_tx[i] == 8'h19) ninth_seen = 1'b1;
      chk("b_dropped_byte_never_sent", 16'(ninth_seen), 16'd0);
      chk("total_starts", 16'(n_starts), 16'd17);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
